// File: rtl/rv_vec_reg_file_mp_if.sv
// Vector register file bundle: writeback ports, reservation request,
// read ports, scoreboard view and the v0 mask export.
interface rv_vec_reg_file_mp_if #(
  parameter int VLEN   = 128,
  parameter int NUM_RS = 3,
  parameter int NUM_WP = 2
);
  logic [NUM_WP-1:0]                 wr_en_i;
  logic [NUM_WP-1:0][4:0]            wr_addr_i;
  logic [NUM_WP-1:0][VLEN-1:0]       wr_data_i;
  logic [NUM_WP-1:0][VLEN/8-1:0]     wr_be_i;
  logic                              rsv_en_i;
  logic [4:0]                        rsv_addr_i;
  logic [NUM_RS-1:0][4:0]            rs_addr_i;
  logic [NUM_RS-1:0][VLEN-1:0]       rs_data_o;
  logic [NUM_RS-1:0]                 rs_busy_o;
  logic [31:0]                       busy_o;
  logic [VLEN-1:0]                   mask_o;
  logic                              wr_conflict_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, wr_be_i,
    output rsv_en_i, rsv_addr_i, rs_addr_i,
    input  rs_data_o, rs_busy_o, busy_o, mask_o, wr_conflict_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, wr_be_i,
    input  rsv_en_i, rsv_addr_i, rs_addr_i,
    output rs_data_o, rs_busy_o, busy_o, mask_o, wr_conflict_o
  );
endinterface

// File: rtl/rv_vec_reg_file_mp.sv
// Multi-write-port RVV register file: 32 x VLEN, byte-masked writes,
// optional write->read bypass and a per-register busy scoreboard.
module rv_vec_reg_file_mp #(
  parameter int VLEN   = 128,
  parameter int NUM_RS = 3,
  parameter int NUM_WP = 2,
  parameter int BYPASS = 1
) (
  input  logic clk_i,
  input  logic arst_i,
  rv_vec_reg_file_mp_if.slave bus
);
  localparam int NB = VLEN / 8;

  logic [31:0][VLEN-1:0] regs_q;
  logic [31:0][VLEN-1:0] regs_d;
  logic [31:0][VLEN-1:0] view;
  logic [31:0]           busy_q;
  logic [31:0]           busy_d;
  logic                  conf_q;
  logic                  conf_d;
  logic [NUM_WP-1:0]     wr_act;

  // Writes are dropped while reset is held so the bypass view reads zero too
  assign wr_act = bus.wr_en_i & {NUM_WP{~arst_i}};

  // Ascending port order lets the highest index win on a shared byte
  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < 32; r++) begin
      for (int p = 0; p < NUM_WP; p++) begin
        if (wr_act[p] && bus.wr_addr_i[p] == 5'(r)) begin
          for (int b = 0; b < NB; b++) begin
            if (bus.wr_be_i[p][b])
              regs_d[r][8*b +: 8] = bus.wr_data_i[p][8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    conf_d = 1'b0;
    for (int p = 0; p < NUM_WP; p++) begin
      for (int q = p + 1; q < NUM_WP; q++) begin
        if (wr_act[p] && wr_act[q] &&
            bus.wr_addr_i[p] == bus.wr_addr_i[q] &&
            |(bus.wr_be_i[p] & bus.wr_be_i[q]))
          conf_d = 1'b1;
      end
    end
  end

  // Reservation applied last so it beats a same-cycle writeback
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WP; p++) begin
      if (wr_act[p])
        busy_d[bus.wr_addr_i[p]] = 1'b0;
    end
    if (bus.rsv_en_i)
      busy_d[bus.rsv_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      regs_q <= '0;
      busy_q <= '0;
      conf_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      conf_q <= conf_d;
    end
  end

  assign view = (BYPASS != 0) ? regs_d : regs_q;

  for (genvar i = 0; i < NUM_RS; i++) begin : g_rd
    assign bus.rs_data_o[i] = view[bus.rs_addr_i[i]];
    assign bus.rs_busy_o[i] = busy_q[bus.rs_addr_i[i]];
  end

  assign bus.mask_o        = view[0];
  assign bus.busy_o        = busy_q;
  assign bus.wr_conflict_o = conf_q;
endmodule

// File: tb/tb_rv_vec_reg_file_mp.sv
// Bench for rv_vec_reg_file_mp: bypass and non-bypass instances share
// stimulus; read expectations flow through a scoreboard queue.
module tb_rv_vec_reg_file_mp;
  localparam int VLEN   = 128;
  localparam int NUM_RS = 3;
  localparam int NUM_WP = 2;
  localparam int NB     = VLEN / 8;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  rv_vec_reg_file_mp_if #(.VLEN(VLEN), .NUM_RS(NUM_RS), .NUM_WP(NUM_WP)) b1 ();
  rv_vec_reg_file_mp_if #(.VLEN(VLEN), .NUM_RS(NUM_RS), .NUM_WP(NUM_WP)) b0 ();

  rv_vec_reg_file_mp #(
    .VLEN(VLEN), .NUM_RS(NUM_RS), .NUM_WP(NUM_WP), .BYPASS(1)
  ) dut1 (.clk_i(clk), .arst_i(arst), .bus(b1));

  rv_vec_reg_file_mp #(
    .VLEN(VLEN), .NUM_RS(NUM_RS), .NUM_WP(NUM_WP), .BYPASS(0)
  ) dut0 (.clk_i(clk), .arst_i(arst), .bus(b0));

  assign b0.wr_en_i    = b1.wr_en_i;
  assign b0.wr_addr_i  = b1.wr_addr_i;
  assign b0.wr_data_i  = b1.wr_data_i;
  assign b0.wr_be_i    = b1.wr_be_i;
  assign b0.rsv_en_i   = b1.rsv_en_i;
  assign b0.rsv_addr_i = b1.rsv_addr_i;
  assign b0.rs_addr_i  = b1.rs_addr_i;

  typedef struct {
    string           tag;
    logic [VLEN-1:0] val;
  } exp_t;

  exp_t            sb[$];
  int              n_chk = 0;
  int              n_fail = 0;
  logic [VLEN-1:0] m  [32];
  logic [VLEN-1:0] mn [32];
  logic [31:0]     mb;
  logic [31:0]     mbn;
  logic            conf_exp;
  logic            conf_n;

  localparam logic [VLEN-1:0] EXP2 = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [VLEN-1:0] A3 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [VLEN-1:0] B3 = 128'h55555555_66666666_77777777_88887777;

  task automatic check(input string tag, input logic [VLEN-1:0] obs,
                       input logic [VLEN-1:0] want);
    n_chk++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  task automatic push(input string tag, input logic [VLEN-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [VLEN-1:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", VLEN'(sb.size()), VLEN'(1));
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic idle();
    b1.wr_en_i    = '0;
    b1.wr_addr_i  = '0;
    b1.wr_data_i  = '0;
    b1.wr_be_i    = '0;
    b1.rsv_en_i   = 1'b0;
    b1.rsv_addr_i = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] a,
                    input logic [VLEN-1:0] d, input logic [NB-1:0] be);
    b1.wr_en_i[p]   = 1'b1;
    b1.wr_addr_i[p] = a;
    b1.wr_data_i[p] = d;
    b1.wr_be_i[p]   = be;
  endtask

  task automatic rsv(input logic [4:0] a);
    b1.rsv_en_i   = 1'b1;
    b1.rsv_addr_i = a;
  endtask

  // Reference next state computed from the currently driven inputs
  task automatic model_next();
    for (int r = 0; r < 32; r++) mn[r] = m[r];
    mbn = mb;
    conf_n = 1'b0;
    for (int p = 0; p < NUM_WP; p++) begin
      if (b1.wr_en_i[p]) begin
        mbn[b1.wr_addr_i[p]] = 1'b0;
        for (int b = 0; b < NB; b++)
          if (b1.wr_be_i[p][b])
            mn[b1.wr_addr_i[p]][8*b +: 8] = b1.wr_data_i[p][8*b +: 8];
      end
    end
    if (b1.rsv_en_i) mbn[b1.rsv_addr_i] = 1'b1;
    if (b1.wr_en_i[0] && b1.wr_en_i[1] &&
        b1.wr_addr_i[0] == b1.wr_addr_i[1] &&
        |(b1.wr_be_i[0] & b1.wr_be_i[1]))
      conf_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    b1.rs_addr_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;

    // Reset state on every register and port
    for (int r = 0; r < 32; r++) begin
      for (int i = 0; i < NUM_RS; i++) begin
        b1.rs_addr_i[i] = 5'((r + i) % 32);
        push("rst_rd1", '0);
        push("rst_rd0", '0);
      end
      #1;
      for (int i = 0; i < NUM_RS; i++) begin
        pop_cmp(b1.rs_data_o[i]);
        pop_cmp(b0.rs_data_o[i]);
      end
    end
    check("rst_busy", b1.busy_o, '0);
    check("rst_mask", b1.mask_o, '0);
    check("rst_conf", VLEN'(b1.wr_conflict_o), '0);
    check("rst_rsbusy", VLEN'(b1.rs_busy_o), '0);

    // Byte-masked write of the low half
    @(negedge clk);
    idle();
    wr(0, 5, '1, 16'h00FF);
    b1.rs_addr_i[0] = 5;
    push("t2_byp", EXP2);
    push("t2_nobyp", '0);
    #2;
    pop_cmp(b1.rs_data_o[0]);
    pop_cmp(b0.rs_data_o[0]);
    @(negedge clk);
    idle();
    push("t2_v5_1", EXP2);
    push("t2_v5_0", EXP2);
    #2;
    pop_cmp(b1.rs_data_o[0]);
    pop_cmp(b0.rs_data_o[0]);
    check("t2_conf", VLEN'(b1.wr_conflict_o), '0);

    // Overlapping two-port write, higher port wins
    @(negedge clk);
    idle();
    wr(0, 3, A3, 16'h000F);
    wr(1, 3, B3, 16'h0003);
    b1.rs_addr_i[0] = 3;
    push("t3_byp", 128'h4444_7777);
    push("t3_nobyp", '0);
    #2;
    pop_cmp(b1.rs_data_o[0]);
    pop_cmp(b0.rs_data_o[0]);
    check("t3_conf_pre", VLEN'(b1.wr_conflict_o), '0);
    @(negedge clk);
    idle();
    push("t3_v3_1", 128'h4444_7777);
    push("t3_v3_0", 128'h4444_7777);
    #2;
    pop_cmp(b1.rs_data_o[0]);
    pop_cmp(b0.rs_data_o[0]);
    check("t3_conf1", VLEN'(b1.wr_conflict_o), 1);
    check("t3_conf0", VLEN'(b0.wr_conflict_o), 1);
    @(negedge clk);
    #2;
    check("t3_conf_off", VLEN'(b1.wr_conflict_o), '0);

    // v0 write with same-cycle read, bypass vs stored
    @(negedge clk);
    idle();
    wr(1, 0, 128'h1234, 16'hFFFF);
    b1.rs_addr_i = '0;
    for (int i = 0; i < NUM_RS; i++) push("t4_byp_rd", 128'h1234);
    push("t4_byp_mask", 128'h1234);
    for (int i = 0; i < NUM_RS; i++) push("t4_nob_rd", '0);
    push("t4_nob_mask", '0);
    #2;
    for (int i = 0; i < NUM_RS; i++) pop_cmp(b1.rs_data_o[i]);
    pop_cmp(b1.mask_o);
    for (int i = 0; i < NUM_RS; i++) pop_cmp(b0.rs_data_o[i]);
    pop_cmp(b0.mask_o);
    @(negedge clk);
    idle();
    push("t4_nob_rd_next", 128'h1234);
    push("t4_nob_mask_next", 128'h1234);
    #2;
    pop_cmp(b0.rs_data_o[0]);
    pop_cmp(b0.mask_o);

    // Scoreboard: reserve, reserve+writeback, writeback
    @(negedge clk);
    idle();
    rsv(7);
    b1.rs_addr_i[0] = 7;
    b1.rs_addr_i[1] = 6;
    #2;
    check("t5_rsbusy_pre", VLEN'(b1.rs_busy_o[0]), '0);
    @(negedge clk);
    idle();
    #2;
    check("t5_busy", b1.busy_o, 32'h80);
    check("t5_rsbusy0", VLEN'(b1.rs_busy_o[0]), 1);
    check("t5_rsbusy1", VLEN'(b1.rs_busy_o[1]), '0);
    check("t5_rsbusy_nob", VLEN'(b0.rs_busy_o[0]), 1);
    @(negedge clk);
    idle();
    rsv(7);
    wr(0, 7, '1, '0);
    @(negedge clk);
    idle();
    #2;
    check("t5_rsv_wins", b1.busy_o, 32'h80);
    @(negedge clk);
    idle();
    wr(1, 7, 128'hBEEF, 16'hFFFF);
    #2;
    check("t5_no_bypass", VLEN'(b1.rs_busy_o[0]), 1);
    @(negedge clk);
    idle();
    #2;
    check("t5_cleared", b1.busy_o, '0);
    check("t5_rs_cleared", VLEN'(b1.rs_busy_o[0]), '0);

    // Asynchronous reset in the middle of activity
    @(negedge clk);
    idle();
    rsv(9);
    wr(0, 10, 128'hCAFE, 16'hFFFF);
    @(negedge clk);
    idle();
    b1.rs_addr_i[0] = 10;
    push("t6_v10", 128'hCAFE);
    #2;
    pop_cmp(b0.rs_data_o[0]);
    check("t6_busy_set", b1.busy_o, 32'h200);
    @(negedge clk);
    idle();
    wr(0, 10, '1, 16'hFFFF);
    wr(1, 11, '1, 16'hFFFF);
    rsv(12);
    #2;
    arst = 1'b1;
    #1;
    push("t6_rst_rd0", '0);
    push("t6_rst_rd1", '0);
    pop_cmp(b0.rs_data_o[0]);
    pop_cmp(b1.rs_data_o[0]);
    check("t6_rst_busy", b1.busy_o, '0);
    check("t6_rst_mask", b0.mask_o, '0);
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    idle();
    b1.rs_addr_i[1] = 11;
    push("t6_v10_after", '0);
    push("t6_v11_after", '0);
    #2;
    pop_cmp(b0.rs_data_o[0]);
    pop_cmp(b0.rs_data_o[1]);
    check("t6_busy_after", b1.busy_o, '0);

    // Random traffic against the reference model
    for (int r = 0; r < 32; r++) m[r] = '0;
    mb = '0;
    conf_exp = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      idle();
      for (int p = 0; p < NUM_WP; p++) begin
        if ($urandom_range(3) != 0)
          wr(p, 5'($urandom_range(5)),
             {$urandom, $urandom, $urandom, $urandom},
             ($urandom_range(2) == 0) ? 16'hFFFF : 16'($urandom));
      end
      if ($urandom_range(2) == 0) rsv(5'($urandom_range(5)));
      for (int i = 0; i < NUM_RS; i++)
        b1.rs_addr_i[i] = 5'($urandom_range(5));
      model_next();
      for (int i = 0; i < NUM_RS; i++) begin
        push("rnd_byp", mn[b1.rs_addr_i[i]]);
        push("rnd_nob", m[b1.rs_addr_i[i]]);
      end
      push("rnd_mask_byp", mn[0]);
      push("rnd_mask_nob", m[0]);
      #2;
      for (int i = 0; i < NUM_RS; i++) begin
        pop_cmp(b1.rs_data_o[i]);
        pop_cmp(b0.rs_data_o[i]);
        check("rnd_rsbusy", VLEN'(b1.rs_busy_o[i]),
              VLEN'(mb[b1.rs_addr_i[i]]));
      end
      pop_cmp(b1.mask_o);
      pop_cmp(b0.mask_o);
      check("rnd_busy", b1.busy_o, mb);
      check("rnd_conf", VLEN'(b1.wr_conflict_o), VLEN'(conf_exp));
      @(posedge clk);
      #1;
      for (int r = 0; r < 32; r++) m[r] = mn[r];
      mb = mbn;
      conf_exp = conf_n;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
